// File: rtl/alu_seq_if.sv
// Byte-loader / ALU / result-handshake bundle for alu_seq_ctrl.
// slave = the sequencer itself, master = the host and ALU side that drives it.
interface alu_seq_if;
   logic       ena;
   logic [7:0] in_data;
   logic       in_strobe;
   logic [6:0] alu_a;
   logic [6:0] alu_b;
   logic [2:0] alu_op;
   logic       alu_start;
   logic [6:0] alu_result;
   logic       alu_carry;
   logic [7:0] res_data;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic       err;

   modport slave (
      input  ena, in_data, in_strobe, alu_result, alu_carry, res_ready,
      output alu_a, alu_b, alu_op, alu_start, res_data, res_valid, busy, err
   );

   modport master (
      output ena, in_data, in_strobe, alu_result, alu_carry, res_ready,
      input  alu_a, alu_b, alu_op, alu_start, res_data, res_valid, busy, err
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Byte-serial ALU sequencer: loads A, B, opcode, issues the ALU, waits ALU_LAT cycles, holds the result.
// Optional macro ALU_SEQ_SYNC_EN inserts a 2-flop synchronizer on in_strobe ahead of edge detection.
module alu_seq_ctrl #(
   parameter int ALU_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_if.slave      bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_B  = 3'd1,
      GET_OP = 3'd2,
      EXEC   = 3'd3,
      WAIT   = 3'd4,
      HOLD   = 3'd5
   } state_t;

   localparam logic [3:0] LAT_C = 4'(ALU_LAT);

   state_t     state_r, state_nxt_s;
   logic [3:0] cnt_r, cnt_nxt_s;
   logic [6:0] alu_a_r, alu_a_nxt_s;
   logic [6:0] alu_b_r, alu_b_nxt_s;
   logic [2:0] alu_op_r, alu_op_nxt_s;
   logic       alu_start_r, alu_start_nxt_s;
   logic [7:0] res_data_r, res_data_nxt_s;
   logic       res_valid_r, res_valid_nxt_s;
   logic       err_r, err_nxt_s;
   logic       busy_r;
   logic       strobe_s;
   logic       strobe_prev_r;
   logic       edge_s;

`ifdef ALU_SEQ_SYNC_EN
   logic [1:0] sync_r;

   // Two-flop synchronizer for the asynchronous strobe pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], bus.in_strobe};
      end
   end

   assign strobe_s = sync_r[1];
`else
   assign strobe_s = bus.in_strobe;
`endif

   // Edge history keeps tracking while disabled so re-enabling cannot fake an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_prev_r <= 1'b0;
      end else begin
         strobe_prev_r <= strobe_s;
      end
   end

   assign edge_s = strobe_s & ~strobe_prev_r;

   // Next-state and datapath decode
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      alu_a_nxt_s     = alu_a_r;
      alu_b_nxt_s     = alu_b_r;
      alu_op_nxt_s    = alu_op_r;
      alu_start_nxt_s = 1'b0;
      res_data_nxt_s  = res_data_r;
      res_valid_nxt_s = res_valid_r;
      err_nxt_s       = err_r;

      case (state_r)
         IDLE: begin
            if (edge_s) begin
               alu_a_nxt_s = bus.in_data[6:0];
               err_nxt_s   = 1'b0;
               state_nxt_s = GET_B;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GET_B: begin
            if (edge_s) begin
               alu_b_nxt_s = bus.in_data[6:0];
               state_nxt_s = GET_OP;
            end else begin
               state_nxt_s = GET_B;
            end
         end
         GET_OP: begin
            if (edge_s) begin
               alu_op_nxt_s = bus.in_data[2:0];
               if (bus.in_data[2:0] > 3'd5) begin
                  err_nxt_s   = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  alu_start_nxt_s = 1'b1;
                  state_nxt_s     = EXEC;
               end
            end else begin
               state_nxt_s = GET_OP;
            end
         end
         EXEC: begin
            cnt_nxt_s   = LAT_C;
            state_nxt_s = WAIT;
            if (edge_s) begin
               err_nxt_s = 1'b1;
            end else begin
               err_nxt_s = err_r;
            end
         end
         WAIT: begin
            if (edge_s) begin
               err_nxt_s = 1'b1;
            end else begin
               err_nxt_s = err_r;
            end
            // The capture edge is the one that takes the counter to zero
            if (cnt_r <= 4'd1) begin
               cnt_nxt_s       = 4'd0;
               res_data_nxt_s  = {bus.alu_carry, bus.alu_result};
               res_valid_nxt_s = 1'b1;
               state_nxt_s     = HOLD;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         HOLD: begin
            if (edge_s) begin
               err_nxt_s = 1'b1;
            end else begin
               err_nxt_s = err_r;
            end
            if (bus.res_ready) begin
               res_valid_nxt_s = 1'b0;
               state_nxt_s     = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and output registers, frozen while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         alu_a_r     <= 7'd0;
         alu_b_r     <= 7'd0;
         alu_op_r    <= 3'd0;
         alu_start_r <= 1'b0;
         res_data_r  <= 8'd0;
         res_valid_r <= 1'b0;
         err_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else if (bus.ena) begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         alu_a_r     <= alu_a_nxt_s;
         alu_b_r     <= alu_b_nxt_s;
         alu_op_r    <= alu_op_nxt_s;
         alu_start_r <= alu_start_nxt_s;
         res_data_r  <= res_data_nxt_s;
         res_valid_r <= res_valid_nxt_s;
         err_r       <= err_nxt_s;
         busy_r      <= (state_nxt_s != IDLE);
      end else begin
         alu_start_r <= 1'b0;
      end
   end

   assign bus.alu_a     = alu_a_r;
   assign bus.alu_b     = alu_b_r;
   assign bus.alu_op    = alu_op_r;
   assign bus.alu_start = alu_start_r;
   assign bus.res_data  = res_data_r;
   assign bus.res_valid = res_valid_r;
   assign bus.busy      = busy_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl (default build, ALU_LAT=1).
module tb_alu_seq_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   start_cnt;
   int   start_base;

   alu_seq_if bus ();

   alu_seq_ctrl #(.ALU_LAT(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.alu_start === 1'b1) start_cnt <= start_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.in_data   = b;
      bus.in_strobe = 1'b1;
      tick();
      bus.in_strobe = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_start} !== 18'd0) begin
         bad++; $display("FAIL reset_alu: got %0h required 0", {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_start});
      end
      total++;
      if ({bus.res_data, bus.res_valid, bus.busy, bus.err} !== 11'd0) begin
         bad++; $display("FAIL reset_res: got %0h required 0", {bus.res_data, bus.res_valid, bus.busy, bus.err});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_add();
      bus.alu_result = 7'h08;
      bus.alu_carry  = 1'b0;
      send_byte(8'h05);
      send_byte(8'h03);
      start_base = start_cnt;
      bus.in_data   = 8'h00;
      bus.in_strobe = 1'b1;
      tick();
      bus.in_strobe = 1'b0;
      total++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {7'h05, 7'h03, 3'h0}) begin
         bad++; $display("FAIL basic_operands: got %0h/%0h/%0h required 5/3/0", bus.alu_a, bus.alu_b, bus.alu_op);
      end
      total++;
      if (bus.alu_start !== 1'b1 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL basic_start: got start=%0b busy=%0b required 1/1", bus.alu_start, bus.busy);
      end
      tick();
      total++;
      if (bus.alu_start !== 1'b0 || bus.res_valid !== 1'b0) begin
         bad++; $display("FAIL basic_pulse: got start=%0b valid=%0b required 0/0", bus.alu_start, bus.res_valid);
      end
      tick();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h08) begin
         bad++; $display("FAIL basic_result: got valid=%0b data=%0h required 1/08", bus.res_valid, bus.res_data);
      end
      total++;
      if (start_cnt - start_base !== 1) begin
         bad++; $display("FAIL basic_start_count: got %0d required 1", start_cnt - start_base);
      end
   endtask

   task automatic test_backpressure();
      int held_bad;
      held_bad = 0;
      bus.alu_result = 7'h55;
      bus.alu_carry  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h08) held_bad++;
      end
      total++;
      if (held_bad !== 0) begin
         bad++; $display("FAIL bp_hold: got %0d unstable cycles required 0", held_bad);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      total++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL bp_release: got valid=%0b busy=%0b required 0/0", bus.res_valid, bus.busy);
      end
   endtask

   task automatic test_illegal_op();
      start_base = start_cnt;
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h07);
      total++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL illegal_err: got err=%0b busy=%0b required 1/0", bus.err, bus.busy);
      end
      total++;
      if (start_cnt !== start_base) begin
         bad++; $display("FAIL illegal_no_start: got %0d starts required 0", start_cnt - start_base);
      end
      send_byte(8'h01);
      total++;
      if (bus.err !== 1'b0 || bus.alu_a !== 7'h01 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL illegal_clear: got err=%0b a=%0h busy=%0b required 0/01/1", bus.err, bus.alu_a, bus.busy);
      end
   endtask

   task automatic test_mid_op_strobe();
      bus.alu_result = 7'h7f;
      bus.alu_carry  = 1'b1;
      send_byte(8'h02);
      send_byte(8'h01);
      bus.in_data   = 8'h66;
      bus.in_strobe = 1'b1;
      tick();
      bus.in_strobe = 1'b0;
      total++;
      if (bus.err !== 1'b1 || bus.res_valid !== 1'b1 || bus.res_data !== 8'hff) begin
         bad++; $display("FAIL midop_result: got err=%0b valid=%0b data=%0h required 1/1/ff", bus.err, bus.res_valid, bus.res_data);
      end
      total++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {7'h01, 7'h02, 3'h1}) begin
         bad++; $display("FAIL midop_operands: got %0h/%0h/%0h required 1/2/1", bus.alu_a, bus.alu_b, bus.alu_op);
      end
      tick();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
         bad++; $display("FAIL midop_sticky: got busy=%0b err=%0b required 0/1", bus.busy, bus.err);
      end
   endtask

   task automatic test_reset_in_wait();
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_start, bus.res_data, bus.res_valid, bus.busy, bus.err} !== 29'd0) begin
         bad++; $display("FAIL async_reset: got %0h required 0",
                         {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_start, bus.res_data, bus.res_valid, bus.busy, bus.err});
      end
      tick();
      rst_n = 1'b1;
      tick();
      send_byte(8'h7f);
      total++;
      if (bus.alu_a !== 7'h7f || bus.busy !== 1'b1) begin
         bad++; $display("FAIL reset_reload: got a=%0h busy=%0b required 7f/1", bus.alu_a, bus.busy);
      end
   endtask

   task automatic test_ena_gating();
      bus.ena = 1'b0;
      send_byte(8'h33);
      send_byte(8'h34);
      total++;
      if (bus.alu_b !== 7'h00 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL ena_frozen: got b=%0h busy=%0b required 00/1", bus.alu_b, bus.busy);
      end
      bus.in_data   = 8'h44;
      bus.in_strobe = 1'b1;
      tick();
      bus.ena = 1'b1;
      tick();
      total++;
      if (bus.alu_b !== 7'h00) begin
         bad++; $display("FAIL ena_no_false_edge: got b=%0h required 00", bus.alu_b);
      end
      bus.in_strobe = 1'b0;
      tick();
      send_byte(8'h55);
      total++;
      if (bus.alu_b !== 7'h55 || bus.alu_a !== 7'h7f) begin
         bad++; $display("FAIL ena_load: got b=%0h a=%0h required 55/7f", bus.alu_b, bus.alu_a);
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      start_cnt      = 0;
      start_base     = 0;
      rst_n          = 1'b0;
      bus.ena        = 1'b1;
      bus.in_data    = 8'h00;
      bus.in_strobe  = 1'b0;
      bus.alu_result = 7'h00;
      bus.alu_carry  = 1'b0;
      bus.res_ready  = 1'b0;
      test_reset();
      test_basic_add();
      test_backpressure();
      test_illegal_op();
      test_mid_op_strobe();
      test_reset_in_wait();
      test_ena_gating();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, fixed ALU latency in cycles from alu_start to a valid alu_result (legal 1..15).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: ena  input  1  enable; high = design selected.
REQ-005 Port: in_data  input  8  operand/opcode byte from the dedicated input pins.
REQ-006 Port: in_strobe  input  1  load strobe; each rising edge loads one byte.
REQ-007 Port: alu_a, alu_b  output  7 each  ALU operands.
REQ-008 Port: alu_op  output  3  ALU opcode.
REQ-009 Port: alu_start  output  1  one-cycle ALU issue pulse.
REQ-010 Port: alu_result  input  7; alu_carry  input  1  ALU outputs, sampled once.
REQ-011 Port: res_data  output  8  {carry, result}, to display/IO.
REQ-012 Port: res_valid  output  1; res_ready  input  1  result handshake.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: err  output  1  sticky protocol error flag.

Function
REQ-015 FSM states SHALL be IDLE, GET_B, GET_OP, EXEC, WAIT, HOLD.
REQ-016 Strobe edge = in_strobe high now and low in the previous sampled cycle; one edge SHALL be consumed per cycle.
REQ-017 IDLE + edge: alu_a <= in_data[6:0], clear err, go to GET_B.
REQ-018 GET_B + edge: alu_b <= in_data[6:0], go to GET_OP.
REQ-019 GET_OP + edge: alu_op <= in_data[2:0]. Opcode 0-5 -> EXEC. Opcode 6-7 -> set err, return to IDLE, no issue.
REQ-020 EXEC: alu_start=1 for exactly one cycle, load latency counter with ALU_LAT, go to WAIT.
REQ-021 WAIT: decrement the counter each cycle. When it reaches 0, res_data <= {alu_carry, alu_result}, res_valid <= 1, go to HOLD. Result therefore SHALL be registered ALU_LAT+1 cycles after the alu_start cycle.
REQ-022 HOLD: res_valid and res_data held stable until res_valid&&res_ready. On that cycle res_valid <= 0 next cycle, state -> IDLE.
REQ-023 A strobe edge in EXEC, WAIT or HOLD SHALL be ignored and SHALL set err. err SHALL stay set until the next operand-A load.
REQ-024 alu_a, alu_b and alu_op SHALL stay stable from capture until the next IDLE load.
REQ-025 ena=0: state, counter and registers frozen; strobe edges ignored; the edge detector still tracks in_strobe, so no false edge when ena returns high.
REQ-026 res_ready high outside HOLD SHALL have no effect. A strobe edge in the handshake cycle is ignored and sets err.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter=0, alu_a=alu_b=0, alu_op=0, alu_start=0, res_data=0, res_valid=0, err=0, busy=0, and edge history=0. Any operation in flight SHALL be discarded.
REQ-028 The first strobe edge after reset release SHALL load operand A.

Configuration
REQ-029 Macro ALU_SEQ_SYNC_EN defined: in_strobe passes through a 2-flop synchronizer (reset to 0) before edge detection, adding 2 cycles to edge recognition. Undefined: in_strobe is edge-detected directly with no added latency.

Verification
REQ-030 Bench SHALL cover basic add, ALU_LAT=1: bytes 0x05, 0x03, 0x00 -> alu_a=5, alu_b=3, alu_op=0; alu_start pulses 1 cycle; ALU returns 0x08, carry 0 -> res_data=0x08, res_valid 2 cycles after start.
REQ-031 Bench SHALL cover backpressure: res_ready low for 10 cycles -> res_data held; then ready pulse -> res_valid drops next cycle, busy=0.
REQ-032 Bench SHALL cover illegal op: bytes 0x01, 0x02, 0x07 -> err=1, no alu_start, IDLE. Next 0x01 load -> err=0.
REQ-033 Bench SHALL cover mid-op strobe: edge during WAIT -> err=1, result still delivered unchanged.
REQ-034 Bench SHALL cover async reset in WAIT: rst_n low mid-cycle -> all outputs 0 without a clock edge; after release, byte 0x7F loads alu_a=0x7F.
REQ-035 Bench SHALL cover ena gating: ena=0 during GET_B with strobe toggling -> no load; ena=1 then one edge -> alu_b loaded.
